pdp11_register_bank: RTL and testbench
======================================

Name: pdp11_register_bank

Overview:
- Parametrised PDP-11 CPU register bank: general registers R0..R(NUM_REGS-1), with SP = R6 and PC = R7 held in the same indexed array.
- Also holds the processor status word (PSW).
- Provides N combinational read ports, one result write port, one autoincrement/autodecrement step port, PC increment/load, and condition-code update.
- Sits between decode/operand-fetch and execute/writeback of the pipeline.

Parameters:
- WIDTH, 16, register and data width in bits; a multiple of 8, minimum 16.
- NUM_REGS, 8, register count; minimum 8; index 6 is SP, index 7 is PC.
- NUM_RD, 2, number of read ports.
- PC_RESET, 16'o001000, PC value on reset.
- SP_RESET, 16'o000776, SP value on reset.
- PSW_RESET, 16'o000340, PSW value on reset (priority 7).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses, flattened; AW = $clog2(NUM_REGS)
- rd_data  out  NUM_RD*WIDTH  read data, flattened
- wr_en  in  1  result write enable
- wr_addr  in  AW  result write register
- wr_data  in  WIDTH  result write data
- wr_byte  in  1  byte-mode result write
- wr_sext  in  1  with wr_byte: sign-extend bit 7 into the whole register (MOVB to register)
- step_en  in  1  autoincrement/autodecrement enable
- step_addr  in  AW  register to step
- step_dec  in  1  1 = decrement, 0 = increment
- step_byte  in  1  byte-sized step
- pc_inc  in  1  PC += 2 (instruction fetch)
- pc_load  in  1  load PC (branch/jump)
- pc_target  in  WIDTH  PC load value
- cc_mask  in  4  per-flag update enable, bit order {N,Z,V,C}
- cc_in  in  4  new flag values, bit order {N,Z,V,C}
- psw_wr  in  1  full PSW write (MTPS / RTI)
- psw_in  in  16  full PSW write value
- pc_out  out  WIDTH  current PC
- sp_out  out  WIDTH  current SP
- psw_out  out  16  current PSW

Behaviour:
- Reset (asynchronous, immediate):
  - R0..R5 and R8+ clear to 0; SP = SP_RESET; PC = PC_RESET; PSW = PSW_RESET.
  - All outputs reflect these values while reset is high, including mid-operation.
- Reads:
  - Combinational, zero latency; return the registered value.
  - An out-of-range address (>= NUM_REGS, only possible when NUM_REGS is not a power of 2) reads 0.
- Writes:
  - All writes take effect on the rising edge of clock.
  - Out-of-range write addresses are ignored.
- Result write (wr_en):
  - Word mode writes all WIDTH bits.
  - wr_byte=1, wr_sext=0: only bits [7:0] change; the upper bits are preserved.
  - wr_byte=1, wr_sext=1: register = sign-extended wr_data[7:0].
- Step port (step_en):
  - Step size is 1 when step_byte=1, otherwise 2.
  - SP and PC always step by 2 regardless of step_byte.
  - Modulo 2^WIDTH: 16'hFFFF + 1 = 0; 0 - 2 = 16'hFFFE. No flags are affected.
- Same-register collision: wr_en and step_en on the same register in one cycle → the result write wins; the step is discarded.
- PC priority, highest first:
  - pc_load
  - result write to R7
  - step on R7
  - pc_inc (PC + 2, wraps modulo 2^WIDTH)
- PC alignment: PC bit 0 is forced to 0 on every update.
- PSW:
  - psw_wr=1 loads psw_in[7:0]; bits [15:8] stay 0.
  - Otherwise each flag whose cc_mask bit is 1 takes the matching cc_in bit.
  - psw_wr takes precedence over cc_mask in the same cycle.
  - The T-bit and priority bits change only via psw_wr or reset.
- Result write to SP: loads SP directly, same rules as any register (byte writes allowed).
- No stall input: the caller gates the enables.

Optional Feature:
- Macro: PDP11_REG_BYPASS_EN.
- When defined: each read port forwards same-cycle write data, with priority:
  - for PC, the pending next-PC value (pc_load/write/step/inc) is forwarded;
  - for all other registers, the pending result write, else the pending step.
  - The forwarded value is exactly what the register will hold after the edge, including byte/sext merging.
  - pc_out, sp_out and psw_out also forward.
- When undefined: reads return the pre-edge value only.

Decomposition:
- Shared package `parameters` holds:
  - localparams REG_SP=6, REG_PC=7, PC_STEP=2;
  - CC bit-index constants CC_N=3, CC_Z=2, CC_V=1, CC_C=0;
  - reuse of the existing processor_status_word_t for the PSW layout.
- Sub-module pdp11_psw_reg: PSW storage and masked update/full-load logic.
- The top level holds the register array, the step/merge datapath and the bypass.

Test Plan:
- Reset high mid-run (PC=16'o002000) → PC=16'o001000, SP=16'o000776, PSW=16'o000340, R3=0, all asynchronous before the next edge.
- R2=16'h12FF; wr_byte=1, wr_data=16'h0080, sext=0 → R2=16'h1280; repeat with sext=1 → R2=16'hFF80.
- step_en on R6=16'o000776, step_dec=1, step_byte=1 → SP=16'o000774; R1=0, step_dec=1, byte → R1=16'hFFFF.
- pc_inc with PC=16'hFFFE → PC=0. pc_load(16'o003000) with pc_inc and step on R7 in the same cycle → PC=16'o003000.
- wr_en R4=16'h5555 and step_en R4 in the same cycle → R4=16'h5555. cc_mask=4'b0101, cc_in=4'b1111, PSW=0 → N=0, Z=1, V=0, C=1; psw_wr with cc_mask set → psw_in wins.
- Bypass defined: wr_en R5=16'hABCD while rd_addr[0]=5 → rd_data[0]=16'hABCD in the same cycle; bypass undefined → old R5 value.

Source files
------------

// File: rtl/pdp11_register_bank_pkg.sv
// Shared constants and PSW layout for the PDP-11 register bank.
package parameters;

    localparam int unsigned REG_SP  = 6;
    localparam int unsigned REG_PC  = 7;
    localparam int unsigned PC_STEP = 2;

    localparam int unsigned CC_N = 3;
    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_V = 1;
    localparam int unsigned CC_C = 0;

    typedef struct packed {
        logic [7:0] upper;
        logic [2:0] ipl;
        logic       t;
        logic       n;
        logic       z;
        logic       v;
        logic       c;
    } processor_status_word_t;

endpackage

// File: rtl/pdp11_register_bank_psw.sv
// PSW storage: full load (MTPS/RTI) or per-flag condition-code update.
module pdp11_psw_reg
    import parameters::*;
#(
    parameter logic [15:0] PSW_RESET = 16'o000340
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [3:0]  i_cc_mask,
    input  logic [3:0]  i_cc_in,
    input  logic        i_psw_wr,
    input  logic [15:0] i_psw_in,
    output logic [15:0] o_psw,
    output logic [15:0] o_psw_next
);

    processor_status_word_t r_psw;
    processor_status_word_t w_psw_next;

    always_comb begin
        w_psw_next = r_psw;
        if (i_psw_wr) begin
            w_psw_next = processor_status_word_t'({8'h00, i_psw_in[7:0]});
        end else begin
            if (i_cc_mask[CC_N]) w_psw_next.n = i_cc_in[CC_N];
            if (i_cc_mask[CC_Z]) w_psw_next.z = i_cc_in[CC_Z];
            if (i_cc_mask[CC_V]) w_psw_next.v = i_cc_in[CC_V];
            if (i_cc_mask[CC_C]) w_psw_next.c = i_cc_in[CC_C];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_psw <= processor_status_word_t'(PSW_RESET);
        else         r_psw <= w_psw_next;
    end

    assign o_psw      = r_psw;
    assign o_psw_next = w_psw_next;

endmodule

// File: rtl/pdp11_register_bank.sv
// PDP-11 register bank: R0..Rn (SP=R6, PC=R7), PSW, read/write/step ports.
// Optional same-cycle read forwarding via `PDP11_REG_BYPASS_EN.
module pdp11_register_bank
    import parameters::*;
#(
    parameter int              WIDTH     = 16,
    parameter int              NUM_REGS  = 8,
    parameter int              NUM_RD    = 2,
    parameter logic [WIDTH-1:0] PC_RESET = WIDTH'(16'o001000),
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(16'o000776),
    parameter logic [15:0]     PSW_RESET = 16'o000340,
    localparam int             AW        = $clog2(NUM_REGS)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NUM_RD*AW-1:0]    i_rd_addr,
    output logic [NUM_RD*WIDTH-1:0] o_rd_data,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_wr_byte,
    input  logic                    i_wr_sext,
    input  logic                    i_step_en,
    input  logic [AW-1:0]           i_step_addr,
    input  logic                    i_step_dec,
    input  logic                    i_step_byte,
    input  logic                    i_pc_inc,
    input  logic                    i_pc_load,
    input  logic [WIDTH-1:0]        i_pc_target,
    input  logic [3:0]              i_cc_mask,
    input  logic [3:0]              i_cc_in,
    input  logic                    i_psw_wr,
    input  logic [15:0]             i_psw_in,
    output logic [WIDTH-1:0]        o_pc_out,
    output logic [WIDTH-1:0]        o_sp_out,
    output logic [15:0]             o_psw_out
);

    logic [WIDTH-1:0] r_regs    [NUM_REGS];
    logic [WIDTH-1:0] w_next    [NUM_REGS];
    logic [WIDTH-1:0] w_view    [NUM_REGS];
    logic [WIDTH-1:0] w_merged  [NUM_REGS];
    logic [WIDTH-1:0] w_stepped [NUM_REGS];
    logic [WIDTH-1:0] w_step_sz [NUM_REGS];
    logic             w_wr_hit  [NUM_REGS];
    logic             w_st_hit  [NUM_REGS];
    logic             w_pc_upd;
    logic [AW-1:0]    w_rd_addr [NUM_RD];
    logic [15:0]      w_psw;
    logic [15:0]      w_psw_next;

    // Generic next value per register; result write beats step on collision.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i]  = i_wr_en   && (i_wr_addr   == AW'(i));
            w_st_hit[i]  = i_step_en && (i_step_addr == AW'(i));
            w_step_sz[i] = (i_step_byte && i != REG_SP && i != REG_PC) ?
                           WIDTH'(1) : WIDTH'(PC_STEP);
            w_stepped[i] = i_step_dec ? (r_regs[i] - w_step_sz[i]) :
                                        (r_regs[i] + w_step_sz[i]);
            if (!i_wr_byte)
                w_merged[i] = i_wr_data;
            else if (i_wr_sext)
                w_merged[i] = {{(WIDTH-8){i_wr_data[7]}}, i_wr_data[7:0]};
            else
                w_merged[i] = {r_regs[i][WIDTH-1:8], i_wr_data[7:0]};
            w_next[i] = r_regs[i];
            if (w_wr_hit[i])      w_next[i] = w_merged[i];
            else if (w_st_hit[i]) w_next[i] = w_stepped[i];
        end

        // PC: load > result write > step > increment, always word-aligned.
        w_pc_upd = i_pc_load || w_wr_hit[REG_PC] || w_st_hit[REG_PC] || i_pc_inc;
        if (i_pc_load)
            w_next[REG_PC] = i_pc_target;
        else if (!w_wr_hit[REG_PC] && !w_st_hit[REG_PC] && i_pc_inc)
            w_next[REG_PC] = r_regs[REG_PC] + WIDTH'(PC_STEP);
        if (w_pc_upd)
            w_next[REG_PC][0] = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_regs[REG_SP] <= SP_RESET;
            r_regs[REG_PC] <= PC_RESET;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= w_next[i];
        end
    end

    pdp11_psw_reg #(
        .PSW_RESET (PSW_RESET)
    ) u_psw (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_cc_mask  (i_cc_mask),
        .i_cc_in    (i_cc_in),
        .i_psw_wr   (i_psw_wr),
        .i_psw_in   (i_psw_in),
        .o_psw      (w_psw),
        .o_psw_next (w_psw_next)
    );

`ifdef PDP11_REG_BYPASS_EN
    // While reset is held the forwarded view must still show reset values.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
            w_view[i] = i_reset ? r_regs[i] : w_next[i];
    end
    assign o_psw_out = i_reset ? w_psw : w_psw_next;
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) w_view[i] = r_regs[i];
    end
    assign o_psw_out = w_psw;
`endif

    always_comb begin
        o_rd_data = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            w_rd_addr[p] = i_rd_addr[p*AW +: AW];
            if (32'(w_rd_addr[p]) < NUM_REGS)
                o_rd_data[p*WIDTH +: WIDTH] = w_view[w_rd_addr[p]];
        end
    end

    assign o_pc_out = w_view[REG_PC];
    assign o_sp_out = w_view[REG_SP];

endmodule

// File: tb/tb_pdp11_register_bank.sv
// Directed self-checking bench for pdp11_register_bank (default 16-bit, 8 regs, 2 read ports).
module tb_pdp11_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en, wr_byte, wr_sext;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        step_en, step_dec, step_byte;
    logic [2:0]  step_addr;
    logic        pc_inc, pc_load;
    logic [15:0] pc_target;
    logic [3:0]  cc_mask, cc_in;
    logic        psw_wr;
    logic [15:0] psw_in;
    logic [15:0] pc_out, sp_out, psw_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pdp11_register_bank #(
        .WIDTH    (16),
        .NUM_REGS (8),
        .NUM_RD   (2)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_wr_byte   (wr_byte),
        .i_wr_sext   (wr_sext),
        .i_step_en   (step_en),
        .i_step_addr (step_addr),
        .i_step_dec  (step_dec),
        .i_step_byte (step_byte),
        .i_pc_inc    (pc_inc),
        .i_pc_load   (pc_load),
        .i_pc_target (pc_target),
        .i_cc_mask   (cc_mask),
        .i_cc_in     (cc_in),
        .i_psw_wr    (psw_wr),
        .i_psw_in    (psw_in),
        .o_pc_out    (pc_out),
        .o_sp_out    (sp_out),
        .o_psw_out   (psw_out)
    );

    task automatic idle();
        wr_en = 0; wr_byte = 0; wr_sext = 0; wr_addr = 0; wr_data = 0;
        step_en = 0; step_dec = 0; step_byte = 0; step_addr = 0;
        pc_inc = 0; pc_load = 0; pc_target = 0;
        cc_mask = 0; cc_in = 0; psw_wr = 0; psw_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic wr_word(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; rd_addr = {3'd6, 3'd3};
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc_out !== 16'o001000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_out, 16'o001000); end
        n_cmp++; if (sp_out !== 16'o000776) begin n_fail++; $display("FAIL reset_sp got %h exp %h", sp_out, 16'o000776); end
        n_cmp++; if (psw_out !== 16'o000340) begin n_fail++; $display("FAIL reset_psw got %h exp %h", psw_out, 16'o000340); end
        n_cmp++; if (rd_data !== {16'o000776, 16'h0000}) begin n_fail++; $display("FAIL reset_rd got %h exp %h", rd_data, {16'o000776, 16'h0000}); end
        rst = 0;
        #1;
    endtask

    task automatic test_byte_write();
        rd_addr = {3'd0, 3'd2};
        wr_word(3'd2, 16'h12FF);
        n_cmp++; if (rd_data[15:0] !== 16'h12FF) begin n_fail++; $display("FAIL word_wr got %h exp 12ff", rd_data[15:0]); end
        wr_en = 1; wr_addr = 3'd2; wr_data = 16'h0080; wr_byte = 1; wr_sext = 0;
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'h1280) begin n_fail++; $display("FAIL byte_wr got %h exp 1280", rd_data[15:0]); end
        wr_en = 1; wr_addr = 3'd2; wr_data = 16'h0080; wr_byte = 1; wr_sext = 1;
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'hFF80) begin n_fail++; $display("FAIL byte_sext got %h exp ff80", rd_data[15:0]); end
        wr_en = 1; wr_addr = 3'd6; wr_data = 16'h3405; wr_byte = 1; wr_sext = 0;
        tick();
        n_cmp++; if (sp_out !== 16'h0105) begin n_fail++; $display("FAIL sp_byte_wr got %h exp 0105", sp_out); end
        wr_word(3'd6, 16'o000776);
    endtask

    task automatic test_step();
        rd_addr = {3'd0, 3'd1};
        step_en = 1; step_addr = 3'd6; step_dec = 1; step_byte = 1;
        tick();
        n_cmp++; if (sp_out !== 16'o000774) begin n_fail++; $display("FAIL sp_step got %h exp %h", sp_out, 16'o000774); end
        step_en = 1; step_addr = 3'd1; step_dec = 1; step_byte = 1;
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL r1_dec_wrap got %h exp ffff", rd_data[15:0]); end
        step_en = 1; step_addr = 3'd1; step_dec = 0; step_byte = 1;
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL r1_inc_wrap got %h exp 0000", rd_data[15:0]); end
        rd_addr = {3'd0, 3'd0};
        step_en = 1; step_addr = 3'd0; step_dec = 1; step_byte = 0;
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'hFFFE) begin n_fail++; $display("FAIL r0_word_dec got %h exp fffe", rd_data[15:0]); end
    endtask

    task automatic test_pc();
        pc_load = 1; pc_target = 16'hFFFE;
        tick();
        n_cmp++; if (pc_out !== 16'hFFFE) begin n_fail++; $display("FAIL pc_load got %h exp fffe", pc_out); end
        pc_inc = 1;
        tick();
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL pc_inc_wrap got %h exp 0000", pc_out); end
        pc_load = 1; pc_target = 16'o003000; pc_inc = 1; step_en = 1; step_addr = 3'd7;
        wr_en = 1; wr_addr = 3'd7; wr_data = 16'h1234;
        tick();
        n_cmp++; if (pc_out !== 16'o003000) begin n_fail++; $display("FAIL pc_prio_load got %h exp %h", pc_out, 16'o003000); end
        wr_en = 1; wr_addr = 3'd7; wr_data = 16'h1234; pc_inc = 1; step_en = 1; step_addr = 3'd7;
        tick();
        n_cmp++; if (pc_out !== 16'h1234) begin n_fail++; $display("FAIL pc_prio_wr got %h exp 1234", pc_out); end
        step_en = 1; step_addr = 3'd7; step_byte = 1; pc_inc = 1;
        tick();
        n_cmp++; if (pc_out !== 16'h1236) begin n_fail++; $display("FAIL pc_step got %h exp 1236", pc_out); end
        pc_load = 1; pc_target = 16'h0701;
        tick();
        n_cmp++; if (pc_out !== 16'h0700) begin n_fail++; $display("FAIL pc_align got %h exp 0700", pc_out); end
    endtask

    task automatic test_collision();
        rd_addr = {3'd4, 3'd0};
        wr_en = 1; wr_addr = 3'd4; wr_data = 16'h5555;
        step_en = 1; step_addr = 3'd4; step_dec = 0;
        tick();
        n_cmp++; if (rd_data[31:16] !== 16'h5555) begin n_fail++; $display("FAIL collision got %h exp 5555", rd_data[31:16]); end
    endtask

    task automatic test_psw();
        psw_wr = 1; psw_in = 16'hFFFF;
        tick();
        n_cmp++; if (psw_out !== 16'h00FF) begin n_fail++; $display("FAIL psw_wr_hi got %h exp 00ff", psw_out); end
        psw_wr = 1; psw_in = 16'h0000;
        tick();
        cc_mask = 4'b0101; cc_in = 4'b1111;
        tick();
        n_cmp++; if (psw_out !== 16'h0005) begin n_fail++; $display("FAIL cc_mask got %h exp 0005", psw_out); end
        psw_wr = 1; psw_in = 16'h00E3; cc_mask = 4'b1111; cc_in = 4'b0000;
        tick();
        n_cmp++; if (psw_out !== 16'h00E3) begin n_fail++; $display("FAIL psw_prio got %h exp 00e3", psw_out); end
        cc_mask = 4'b1111; cc_in = 4'b1000;
        tick();
        n_cmp++; if (psw_out !== 16'h00E8) begin n_fail++; $display("FAIL cc_keep_ipl got %h exp 00e8", psw_out); end
    endtask

    task automatic test_bypass();
        rd_addr = {3'd0, 3'd5};
        wr_word(3'd5, 16'h1111);
        wr_en = 1; wr_addr = 3'd5; wr_data = 16'hABCD;
        #1;
`ifdef PDP11_REG_BYPASS_EN
        n_cmp++; if (rd_data[15:0] !== 16'hABCD) begin n_fail++; $display("FAIL bypass_fwd got %h exp abcd", rd_data[15:0]); end
`else
        n_cmp++; if (rd_data[15:0] !== 16'h1111) begin n_fail++; $display("FAIL bypass_off got %h exp 1111", rd_data[15:0]); end
`endif
        tick();
        n_cmp++; if (rd_data[15:0] !== 16'hABCD) begin n_fail++; $display("FAIL r5_after got %h exp abcd", rd_data[15:0]); end
    endtask

    task automatic test_async_reset();
        rd_addr = {3'd0, 3'd3};
        wr_word(3'd3, 16'h3333);
        pc_load = 1; pc_target = 16'o002000;
        tick();
        n_cmp++; if (pc_out !== 16'o002000) begin n_fail++; $display("FAIL pre_reset_pc got %h exp %h", pc_out, 16'o002000); end
        pc_inc = 1; wr_en = 1; wr_addr = 3'd3; wr_data = 16'h7777;
        rst = 1;
        #1;
        n_cmp++; if (pc_out !== 16'o001000) begin n_fail++; $display("FAIL async_pc got %h exp %h", pc_out, 16'o001000); end
        n_cmp++; if (sp_out !== 16'o000776) begin n_fail++; $display("FAIL async_sp got %h exp %h", sp_out, 16'o000776); end
        n_cmp++; if (psw_out !== 16'o000340) begin n_fail++; $display("FAIL async_psw got %h exp %h", psw_out, 16'o000340); end
        n_cmp++; if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL async_r3 got %h exp 0000", rd_data[15:0]); end
        @(posedge clk);
        #1;
        n_cmp++; if (pc_out !== 16'o001000) begin n_fail++; $display("FAIL held_pc got %h exp %h", pc_out, 16'o001000); end
        idle();
        rst = 0;
        #1;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        test_reset();
        test_byte_write();
        test_step();
        test_pc();
        test_collision();
        test_psw();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
